// File: rtl/axil_cfgseq.sv
// axil_cfgseq: AXI-lite master that writes a 128-bit configuration as four
// 32-bit words to byte addresses 0, 4, 8 and 12 of a register slave, then
// (optionally) reads them back and compares against the latched value.
// Exactly one AXI transaction is outstanding at any time.
module axil_cfgseq #(
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter bit OPT_READBACK     = 1'b1,
    parameter bit OPT_LOWPOWER     = 1'b0
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    // Local control
    input  logic                        i_start,
    input  logic [127:0]                i_cfg,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic [127:0]                o_rdback,
    // Write address channel
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    // Write data channel
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    output logic [31:0]                 M_AXI_WDATA,
    output logic [3:0]                  M_AXI_WSTRB,
    // Write response channel
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    // Read address channel
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    // Read data channel
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    input  logic [31:0]                 M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_READ,
        S_RRESP,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [127:0]   cfg_q, cfg_d;
    logic [127:0]   rdback_q, rdback_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           bready_q, bready_d;
    logic           arvalid_q, arvalid_d;
    logic           rready_q, rready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    // Bit offset of the current word inside the 128-bit configuration.
    logic [6:0]     word_lsb;
    logic [31:0]    cfg_word;
    logic [C_AXI_ADDR_WIDTH-1:0] word_addr;

    assign word_lsb = {idx_q, 5'b00000};
    assign cfg_word = cfg_q[word_lsb +: 32];

    // Byte address of the current word: index in [3:2], everything else zero.
    always_comb begin
        word_addr      = '0;
        word_addr[3:2] = idx_q;
    end

    // AXI outputs come straight from registers; address/data only depend on
    // idx_q and cfg_q, which are frozen while a request is pending.
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = 4'hf;
    assign M_AXI_AWADDR  = (OPT_LOWPOWER && !awvalid_q) ? '0 : word_addr;
    assign M_AXI_ARADDR  = (OPT_LOWPOWER && !arvalid_q) ? '0 : word_addr;
    assign M_AXI_WDATA   = (OPT_LOWPOWER && !wvalid_q)  ? '0 : cfg_word;

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign o_rdback = rdback_q;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cfg_d     = cfg_q;
        rdback_d  = rdback_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_WADDR;
                    cfg_d     = i_cfg;
                    err_d     = 1'b0;
                    idx_d     = 2'd0;
                    busy_d    = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end

            S_WADDR: begin
                // AW and W retire independently; leave once neither is pending.
                if (M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end

            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        if (OPT_READBACK) begin
                            state_d   = S_READ;
                            arvalid_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end

            S_READ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RRESP;
                end
            end

            S_RRESP: begin
                if (M_AXI_RVALID) begin
                    rready_d                  = 1'b0;
                    rdback_d[word_lsb +: 32]  = M_AXI_RDATA;
                    if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != cfg_word)) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset clears everything at once.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            cfg_q     <= '0;
            rdback_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cfg_q     <= cfg_d;
            rdback_q  <= rdback_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_axil_cfgseq.sv
// Testbench for axil_cfgseq: instance 0 has read-back enabled, instance 1
// has it disabled. Each instance talks to a small register-slave model
// with optional AW/W stalls, BRESP error injection and RDATA corruption.
module tb_axil_cfgseq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bit stall_en, berr_en, rcor_en;
    logic         start [2];
    logic [127:0] cfg   [2];

    wire          done_a     [2];
    wire          busy_a     [2];
    wire          err_a      [2];
    wire [127:0]  rdback_a   [2];
    wire          awvalid_a  [2];
    wire          wvalid_a   [2];
    wire          arvalid_a  [2];
    wire          bready_a   [2];
    wire          rready_a   [2];
    wire [31:0]   b_cnt_a    [2];
    wire [31:0]   ar_cnt_a   [2];
    wire [31:0]   b_w2_a     [2];
    wire [31:0]   stab_a     [2];
    wire [31:0]   aw_st2_a   [2];
    wire [31:0]   done_cnt_a [2];
    wire [127:0]  mem_a      [2];
    wire [15:0]   walog_a    [2];
    wire [3:0]    st_addr_a  [2];
    wire [31:0]   st_data_a  [2];
    wire [9:0]    misc_a     [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic        awvalid, awready, wvalid, wready, bvalid, bready;
        logic        arvalid, arready, rvalid, rready;
        logic [3:0]  awaddr, araddr, wstrb;
        logic [2:0]  awprot, arprot;
        logic [31:0] wdata, rdata;
        logic [1:0]  bresp, rresp;
        logic        busy, done, err;
        logic [127:0] rdback;

        axil_cfgseq #(
            .C_AXI_ADDR_WIDTH(4),
            .OPT_READBACK    (gi == 0),
            .OPT_LOWPOWER    (1'b0)
        ) u_dut (
            .S_AXI_ACLK   (clk),
            .S_AXI_ARESETN(rst_n),
            .i_start      (start[gi]),
            .i_cfg        (cfg[gi]),
            .o_busy       (busy),
            .o_done       (done),
            .o_err        (err),
            .o_rdback     (rdback),
            .M_AXI_AWVALID(awvalid),
            .M_AXI_AWREADY(awready),
            .M_AXI_AWADDR (awaddr),
            .M_AXI_AWPROT (awprot),
            .M_AXI_WVALID (wvalid),
            .M_AXI_WREADY (wready),
            .M_AXI_WDATA  (wdata),
            .M_AXI_WSTRB  (wstrb),
            .M_AXI_BVALID (bvalid),
            .M_AXI_BREADY (bready),
            .M_AXI_BRESP  (bresp),
            .M_AXI_ARVALID(arvalid),
            .M_AXI_ARREADY(arready),
            .M_AXI_ARADDR (araddr),
            .M_AXI_ARPROT (arprot),
            .M_AXI_RVALID (rvalid),
            .M_AXI_RREADY (rready),
            .M_AXI_RDATA  (rdata),
            .M_AXI_RRESP  (rresp)
        );

        // Slave model state
        logic        aw_got, w_got, prev_aw_stall, prev_w_stall;
        logic [3:0]  aw_l, prev_awaddr;
        logic [31:0] w_l, prev_wdata;
        logic [1:0]  wr_idx;
        logic [31:0] mem [4];
        int          aw_wait, w_wait;
        int          b_cnt = 0, ar_cnt = 0, b_w2 = 0, stab_bad = 0, aw_st2 = 0, done_cnt = 0;
        logic [15:0] wa_log = '0;
        logic [3:0]  st_addr = '0;
        logic [31:0] st_data = '0;

        wire stall_on = stall_en && (gi == 0) && (wr_idx == 2'd2);
        assign awready = awvalid && !aw_got && (!stall_on || aw_wait >= 3);
        assign wready  = wvalid && !w_got && (!stall_on || w_wait >= 1);
        assign arready = arvalid && !rvalid;
        wire [3:0]  aw_eff  = aw_got ? aw_l : awaddr;
        wire [31:0] w_eff   = w_got ? w_l : wdata;
        wire        wr_fire = (aw_got || awready) && (w_got || wready) && !bvalid;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
                bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
                wr_idx <= 2'd0; prev_aw_stall <= 1'b0; prev_w_stall <= 1'b0;
                aw_l <= '0; w_l <= '0; prev_awaddr <= '0; prev_wdata <= '0;
                for (int i = 0; i < 4; i++) mem[i] <= '0;
            end else begin
                if (awvalid && !awready && !aw_got) aw_wait <= aw_wait + 1;
                if (wvalid && !wready && !w_got) w_wait <= w_wait + 1;
                if (awready) begin aw_got <= 1'b1; aw_l <= awaddr; aw_wait <= 0; end
                if (wready)  begin w_got <= 1'b1; w_l <= wdata; w_wait <= 0; end
                if (wr_fire) begin
                    mem[aw_eff[3:2]] <= w_eff;
                    wa_log <= {aw_eff, wa_log[15:4]};
                    bvalid <= 1'b1;
                    bresp  <= (berr_en && gi == 0 && wr_idx == 2'd1) ? 2'b10 : 2'b00;
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                end
                if (bvalid && bready) begin
                    bvalid <= 1'b0;
                    b_cnt  <= b_cnt + 1;
                    wr_idx <= wr_idx + 2'd1;
                    if (wr_idx == 2'd2) b_w2 <= b_w2 + 1;
                end
                if (arready) begin
                    rvalid <= 1'b1;
                    rdata  <= (rcor_en && gi == 0 && araddr[3:2] == 2'd3) ? 32'h0 : mem[araddr[3:2]];
                    rresp  <= 2'b00;
                    ar_cnt <= ar_cnt + 1;
                end
                if (rvalid && rready) rvalid <= 1'b0;
                // Address/data must hold while VALID is high and READY low
                prev_aw_stall <= awvalid && !awready;
                prev_awaddr   <= awaddr;
                prev_w_stall  <= wvalid && !wready;
                prev_wdata    <= wdata;
                if (prev_aw_stall && (!awvalid || awaddr != prev_awaddr)) stab_bad <= stab_bad + 1;
                if (prev_w_stall && (!wvalid || wdata != prev_wdata)) stab_bad <= stab_bad + 1;
                if (awvalid && !awready && wr_idx == 2'd2) begin aw_st2 <= aw_st2 + 1; st_addr <= awaddr; end
                if (wvalid && !wready && wr_idx == 2'd2) st_data <= wdata;
                if (done) done_cnt <= done_cnt + 1;
            end
        end

        assign done_a[gi] = done;       assign busy_a[gi] = busy;
        assign err_a[gi] = err;         assign rdback_a[gi] = rdback;
        assign awvalid_a[gi] = awvalid; assign wvalid_a[gi] = wvalid;
        assign arvalid_a[gi] = arvalid; assign bready_a[gi] = bready;
        assign rready_a[gi] = rready;   assign b_cnt_a[gi] = b_cnt;
        assign ar_cnt_a[gi] = ar_cnt;   assign b_w2_a[gi] = b_w2;
        assign stab_a[gi] = stab_bad;   assign aw_st2_a[gi] = aw_st2;
        assign done_cnt_a[gi] = done_cnt;
        assign mem_a[gi] = {mem[3], mem[2], mem[1], mem[0]};
        assign walog_a[gi] = wa_log;    assign st_addr_a[gi] = st_addr;
        assign st_data_a[gi] = st_data;
        assign misc_a[gi] = {awprot, arprot, wstrb};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_awvalid"}, awvalid_a[0], 1'b0);
        chk({pfx, "_wvalid"},  wvalid_a[0],  1'b0);
        chk({pfx, "_arvalid"}, arvalid_a[0], 1'b0);
        chk({pfx, "_bready"},  bready_a[0],  1'b0);
        chk({pfx, "_rready"},  rready_a[0],  1'b0);
        chk({pfx, "_busy"},    busy_a[0],    1'b0);
        chk({pfx, "_done"},    done_a[0],    1'b0);
        chk({pfx, "_err"},     err_a[0],     1'b0);
        chk({pfx, "_rdback"},  rdback_a[0],  128'h0);
    endtask

    // Start a run on instance g; returns the cycle (relative to the start
    // edge) in which o_done was seen, or -1 on timeout.
    task automatic run(input int g, input logic [127:0] c, input bit dbl,
                       output int dcyc, output logic busy1, output logic err1);
        int k;
        cfg[g] = c;
        @(negedge clk); start[g] = 1'b1;
        @(posedge clk); @(negedge clk);
        start[g] = 1'b0;
        cfg[g]   = ~c;
        busy1 = busy_a[g];
        err1  = err_a[g];
        dcyc  = -1;
        k     = 1;
        while (k < 100 && dcyc < 0) begin
            if (done_a[g]) begin
                dcyc = k;
            end else begin
                start[g] = dbl && (k == 5);
                @(posedge clk); @(negedge clk);
                k++;
            end
        end
        start[g] = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] cfg_a, cfg_b;
        logic [31:0]  b0, ar0, d0, w20, st0;
        logic         busy1, err1;
        int           dcyc, k;

        cfg_a = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};
        cfg_b = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        rst_n = 1'b0;
        stall_en = 1'b0; berr_en = 1'b0; rcor_en = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        cfg[0] = '0; cfg[1] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait run
        b0 = b_cnt_a[0]; ar0 = ar_cnt_a[0]; d0 = done_cnt_a[0];
        run(0, cfg_a, 1'b0, dcyc, busy1, err1);
        $display("txn t1_zero_wait: done at N+%0d err=%0d rdback=%h", dcyc, err_a[0], rdback_a[0]);
        chk("t1_busy_n1", busy1, 1'b1);
        chk("t1_done_cyc", dcyc, 17);
        chk("t1_err", err_a[0], 1'b0);
        chk("t1_rdback", rdback_a[0], cfg_a);
        chk("t1_mem", mem_a[0], cfg_a);
        chk("t1_addr_order", walog_a[0], 16'hc840);
        chk("t1_b_count", b_cnt_a[0] - b0, 4);
        chk("t1_ar_count", ar_cnt_a[0] - ar0, 4);
        chk("t1_done_count", done_cnt_a[0] - d0, 1);
        chk("t1_const_fields", misc_a[0], 10'h00f);

        // AW stalled 3 cycles, W stalled 1 cycle on word 2
        stall_en = 1'b1;
        b0 = b_cnt_a[0]; w20 = b_w2_a[0]; st0 = aw_st2_a[0];
        run(0, cfg_a, 1'b0, dcyc, busy1, err1);
        stall_en = 1'b0;
        $display("txn t2_stall: done at N+%0d stall_addr=%h stall_data=%h", dcyc, st_addr_a[0], st_data_a[0]);
        chk("t2_done_cyc", dcyc, 20);
        chk("t2_stability", stab_a[0], 0);
        chk("t2_stall_addr", st_addr_a[0], 4'h8);
        chk("t2_stall_data", st_data_a[0], 32'hcccc0002);
        chk("t2_stall_cycles", aw_st2_a[0] - st0, 3);
        chk("t2_b_word2", b_w2_a[0] - w20, 1);
        chk("t2_b_count", b_cnt_a[0] - b0, 4);
        chk("t2_err", err_a[0], 1'b0);
        chk("t2_rdback", rdback_a[0], cfg_a);

        // BRESP=SLVERR on word 1
        berr_en = 1'b1;
        b0 = b_cnt_a[0]; ar0 = ar_cnt_a[0];
        run(0, cfg_b, 1'b0, dcyc, busy1, err1);
        berr_en = 1'b0;
        $display("txn t3_bresp_err: done at N+%0d err=%0d", dcyc, err_a[0]);
        chk("t3_done_cyc", dcyc, 17);
        chk("t3_err", err_a[0], 1'b1);
        chk("t3_b_count", b_cnt_a[0] - b0, 4);
        chk("t3_ar_count", ar_cnt_a[0] - ar0, 4);
        chk("t3_rdback", rdback_a[0], cfg_b);

        // RDATA word 3 corrupted; err from previous run clears on start
        rcor_en = 1'b1;
        run(0, cfg_a, 1'b0, dcyc, busy1, err1);
        rcor_en = 1'b0;
        $display("txn t4_rdata_bad: done at N+%0d err=%0d rdback=%h", dcyc, err_a[0], rdback_a[0]);
        chk("t4_err_cleared", err1, 1'b0);
        chk("t4_done_cyc", dcyc, 17);
        chk("t4_err", err_a[0], 1'b1);
        chk("t4_rdback_hi", rdback_a[0][127:96], 32'h0);
        chk("t4_rdback_lo", rdback_a[0][95:0], cfg_a[95:0]);

        // Write-only instance
        b0 = b_cnt_a[1]; ar0 = ar_cnt_a[1];
        run(1, cfg_a, 1'b0, dcyc, busy1, err1);
        $display("txn t5_no_readback: done at N+%0d ar=%0d", dcyc, ar_cnt_a[1] - ar0);
        chk("t5_done_cyc", dcyc, 9);
        chk("t5_ar_count", ar_cnt_a[1] - ar0, 0);
        chk("t5_b_count", b_cnt_a[1] - b0, 4);
        chk("t5_mem", mem_a[1], cfg_a);
        chk("t5_err", err_a[1], 1'b0);
        chk("t5_rdback", rdback_a[1], 128'h0);

        // Reset during RRESP of word 1
        ar0 = ar_cnt_a[0];
        cfg[0] = cfg_a;
        @(negedge clk); start[0] = 1'b1;
        @(posedge clk); @(negedge clk); start[0] = 1'b0;
        k = 0;
        while (k < 50 && !(rready_a[0] && (ar_cnt_a[0] - ar0) == 2)) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        chk("t6_reached_rresp1", k < 50, 1'b1);
        rst_n = 1'b0;
        #1;
        $display("txn t6_reset_midrun: busy=%0d done=%0d err=%0d", busy_a[0], done_a[0], err_a[0]);
        chk_idle("t6_midrun");
        d0 = done_cnt_a[0];
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("t6_no_done", done_cnt_a[0] - d0, 0);

        // Clean run after reset with a second start pulse while busy
        d0 = done_cnt_a[0];
        run(0, cfg_a, 1'b1, dcyc, busy1, err1);
        repeat (5) @(negedge clk);
        $display("txn t7_double_start: done at N+%0d pulses=%0d", dcyc, done_cnt_a[0] - d0);
        chk("t7_done_cyc", dcyc, 17);
        chk("t7_done_once", done_cnt_a[0] - d0, 1);
        chk("t7_err", err_a[0], 1'b0);
        chk("t7_rdback", rdback_a[0], cfg_a);
        chk("t7_busy_after", busy_a[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_cfgseq.md
# axil_cfgseq

AXI-lite master that configures and verifies the four-register AXI-lite control slave. On a start request it writes a 128-bit configuration as four 32-bit words to byte addresses 0, 4, 8 and 12. It then reads all four words back, compares them against the latched configuration, and reports done and error status. It sits between local control logic and the register slave, and is the only master driving that slave's port.

## Interface
- C_AXI_ADDR_WIDTH, 4: master address width; the word index occupies bits [3:2] and all other bits are zero.
- OPT_READBACK, 1: when 0, the read/compare phase is skipped.
- OPT_LOWPOWER, 0: when 1, M_AXI_AWADDR/WDATA/ARADDR are driven to zero whenever the corresponding VALID is low.
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
- i_start  in  1  start request; sampled only in IDLE.
- i_cfg  in  128  configuration; word k = i_cfg[32k+31:32k]; latched on start.
- o_busy  out  1  high from the cycle after start acceptance until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  result of the most recent run; valid from o_done until the next start.
- o_rdback  out  128  read-back words, same packing as i_cfg.
- M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWADDR out C_AXI_ADDR_WIDTH, M_AXI_AWPROT out 3 (always 0).
- M_AXI_WVALID out 1, M_AXI_WREADY in 1, M_AXI_WDATA out 32, M_AXI_WSTRB out 4 (always 4'hf).
- M_AXI_BVALID in 1, M_AXI_BREADY out 1, M_AXI_BRESP in 2.
- M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_ARADDR out C_AXI_ADDR_WIDTH, M_AXI_ARPROT out 3 (always 0).
- M_AXI_RVALID in 1, M_AXI_RREADY out 1, M_AXI_RDATA in 32, M_AXI_RRESP in 2.

## Operation
- States:
  - IDLE → WADDR on i_start. In this transition the block latches i_cfg, clears o_err, sets idx=0 and asserts o_busy.
  - WADDR: AWVALID and WVALID rise together. Each drops independently on its own handshake. When both have completed → WRESP.
  - WRESP: BREADY=1. On the B handshake, o_err is set if BRESP≠2'b00. If idx=3 → READ (or DONE when OPT_READBACK=0), with idx reset to 0; otherwise idx++ → WADDR.
  - READ: ARVALID=1 until the AR handshake → RRESP.
  - RRESP: RREADY=1. On the R handshake:
    - o_rdback[idx] ← RDATA.
    - o_err is set if RRESP≠0 or RDATA≠latched word idx.
    - If idx=3 → DONE; otherwise idx++ → READ.
  - DONE: o_done=1 for one cycle, o_busy drops → IDLE.
- AWADDR=ARADDR={idx,2'b00}. WDATA is latched word idx.
- Address and data are stable while VALID is high and READY is low. VALID never drops before its handshake.
- At most one transaction is outstanding. The next AW/AR is not issued before the prior B/R handshake.
- i_start is ignored outside IDLE; i_cfg changes after acceptance have no effect.
- o_err is sticky within a run. The run always completes all transactions, even after an error.
- BREADY is low outside WRESP and RREADY is low outside RRESP. Responses arriving in any other state are protocol violations and are not handled.
- Reset mid-run:
  - All VALIDs, READYs, o_busy, o_done, o_err and o_rdback clear immediately.
  - State returns to IDLE and o_done is not pulsed.
  - The slave must be reset concurrently.

## Timing
- Reset values: all M_AXI VALIDs 0, BREADY 0, RREADY 0, o_busy 0, o_done 0, o_err 0, o_rdback 0, state IDLE.
- Start sampled at edge N: AWVALID/WVALID/o_busy are high in cycle N+1.
- Turnaround: the next request's VALID rises in the cycle after the previous B/R handshake.
- Against a slave with 1-cycle ready and response (easyaxil-like), o_done is high at N+17 with OPT_READBACK=1 and at N+9 with OPT_READBACK=0.
- AWREADY and WREADY may arrive in different cycles. WRESP is entered the cycle after the later of the two handshakes.
- A new start may be sampled in the cycle after o_done.

## Test plan
- Zero-wait slave, i_cfg={32'hdddd0003,32'hcccc0002,32'hbbbb0001,32'haaaa0000}, start at N:
  - writes go to addresses 0,4,8,12 with matching data;
  - o_rdback equals i_cfg;
  - o_err=0;
  - o_done pulses at N+17.
- AWREADY delayed 3 cycles and WREADY delayed 1 cycle on word 2:
  - AWADDR=8 and WDATA=32'hcccc0002 hold stable while stalled;
  - exactly one B handshake occurs;
  - completion shifts by 3 cycles.
- Slave returns BRESP=2'b10 on word 1: all 8 transactions still complete, o_err=1 at o_done, and o_err clears on the next start.
- Slave corrupts RDATA word 3 to 32'h0: o_rdback[127:96]=0 and o_err=1. With OPT_READBACK=0, there is no AR activity and o_done pulses at N+9.
- Reset:
  - S_AXI_ARESETN low during RRESP of word 1: every output is 0 within the same cycle and no o_done follows.
  - After release, a new start performs a full clean run.
  - A second i_start pulse while busy is ignored, and o_done pulses exactly once.
